// File: rtl/iq_demod_pkg.sv
// Shared types and constants for the IQ pair framer and its sample bank.
// The optional IQ_FRAMER_SAT_EN build is handled in iq_sample_bank.
package iq_demod_pkg;

  localparam int SAMPLE_W    = 9;
  localparam int NUM_SAMPLES = 10;
  localparam int NUM_PAIRS   = 5;
  localparam int IDX_W       = 4;
  localparam int SEL_W       = 3;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } framer_state_t;

  localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PAIRS - 1);

endpackage

// File: rtl/iq_sample_bank.sv
// Ten-entry registered sample bank written by index.
// Build option IQ_FRAMER_SAT_EN folds the most negative sample onto -(2^(W-1)-1).
module iq_sample_bank
  import iq_demod_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  sample_t          wr_data,
  output sample_t          bank [NUM_SAMPLES]
);

`ifdef IQ_FRAMER_SAT_EN
  function automatic sample_t sat_sample(input sample_t s);
    sat_sample = (s == SAMPLE_MIN) ? sample_t'(SAMPLE_MIN + sample_t'(1)) : s;
  endfunction
`endif

  sample_t wr_val;
  sample_t bank_q [NUM_SAMPLES];
  sample_t bank_d [NUM_SAMPLES];

  always_comb begin
`ifdef IQ_FRAMER_SAT_EN
    wr_val = sat_sample(wr_data);
`else
    wr_val = wr_data;
`endif
  end

  always_comb begin
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      bank_d[i] = bank_q[i];
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        bank_d[i] = wr_val;
      end
    end
  end

  // bank registers: cleared only by reset, otherwise overwritten entry by entry
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_SAMPLES; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SAMPLES; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign bank = bank_q;

endmodule

// File: rtl/iq_pair_framer.sv
// Collects ten serial I/Q samples, then presents them as five pairs under valid/ready.
// Build option IQ_FRAMER_SAT_EN (see iq_sample_bank) saturates -256 to -255 on write.
module iq_pair_framer #(
  parameter int SAMPLE_W = 9
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       clear,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [SAMPLE_W-1:0] bank_0,
  output logic signed [SAMPLE_W-1:0] bank_1,
  output logic signed [SAMPLE_W-1:0] bank_2,
  output logic signed [SAMPLE_W-1:0] bank_3,
  output logic signed [SAMPLE_W-1:0] bank_4,
  output logic signed [SAMPLE_W-1:0] bank_5,
  output logic signed [SAMPLE_W-1:0] bank_6,
  output logic signed [SAMPLE_W-1:0] bank_7,
  output logic signed [SAMPLE_W-1:0] bank_8,
  output logic signed [SAMPLE_W-1:0] bank_9,
  output logic [2:0]                 sel,
  output logic                       pair_valid,
  input  logic                       pair_ready,
  output logic                       pair_last
);

  import iq_demod_pkg::*;

  framer_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             wr_en;
  sample_t          bank [NUM_SAMPLES];

  // Handshake readiness is decoded from state only, so the accept terms below
  // reduce to the raw valid/ready inputs in the matching state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    wr_en   = 1'b0;
    if (clear) begin
      state_d = FILL;
      idx_d   = '0;
      sel_d   = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid) begin
            wr_en = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              sel_d   = '0;
              state_d = DRAIN;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (pair_ready) begin
            if (sel_q == LAST_SEL) begin
              sel_d   = '0;
              state_d = FILL;
            end else begin
              sel_d = sel_q + SEL_W'(1);
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= FILL;
      idx_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
    end
  end

  iq_sample_bank u_bank (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (sample_t'(in_sample)),
    .bank    (bank)
  );

  assign in_ready   = (state_q == FILL);
  assign pair_valid = (state_q == DRAIN);
  assign pair_last  = (state_q == DRAIN) && (sel_q == LAST_SEL);
  assign sel        = sel_q;

  assign bank_0 = bank[0];
  assign bank_1 = bank[1];
  assign bank_2 = bank[2];
  assign bank_3 = bank[3];
  assign bank_4 = bank[4];
  assign bank_5 = bank[5];
  assign bank_6 = bank[6];
  assign bank_7 = bank[7];
  assign bank_8 = bank[8];
  assign bank_9 = bank[9];

endmodule
